adc_param_scheduler: RTL and testbench

Sequences the SPI ADC controller: issues periodic conversion requests and averages 2^AVG_LOG2 samples per channel. Applies a hysteresis filter, then publishes new duty/period values to the clock divider only on a master-cycle boundary, so outputs never glitch mid-period. It sits between spi_controller (ch0 = duty, ch1 = period) and the period mux/clk_divider in top. It replaces the free-running valid-capture register there.

---
 rtl/timekeeper_pkg.sv | 16 +
 rtl/sample_averager.sv | 71 +++++++
 rtl/adc_param_scheduler.sv | 168 ++++++++++++++++
 tb/tb_adc_param_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timekeeper_pkg.sv
// Shared types and defaults for the ADC sampling and publish path.
package timekeeper_pkg;

  localparam int CLK_HZ             = 12_000_000;
  localparam int DEFAULT_DATA_WIDTH = 10;
  localparam int DEFAULT_SAMPLE_DIV = CLK_HZ / 1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_ACCUM,
    ST_EVAL
  } sched_state_e;

endpackage

// File: rtl/sample_averager.sv
// Two-channel sample accumulator: averages 2^AVG_LOG2 samples and flags a
// candidate that differs from the published pair by more than HYST.
module sample_averager
  import timekeeper_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int AVG_LOG2   = 2,
  parameter int HYST       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accum_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] s0_i,
  input  logic [DATA_WIDTH-1:0] s1_i,
  input  logic [DATA_WIDTH-1:0] pub0_i,
  input  logic [DATA_WIDTH-1:0] pub1_i,
  output logic                  last_o,
  output logic [DATA_WIDTH-1:0] avg0_o,
  output logic [DATA_WIDTH-1:0] avg1_o,
  output logic                  changed_o
);

  localparam int AW = DATA_WIDTH + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;

  logic [AW-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic exceeds(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] diff;
    diff = (a > b) ? a - b : b - a;
    return diff > DATA_WIDTH'(HYST);
  endfunction

  // NOTE: every _d is given its hold value first, so no branch can infer a latch.
  always_comb begin
    acc0_d = acc0_q;
    acc1_d = acc1_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      acc0_d = '0;
      acc1_d = '0;
      cnt_d  = '0;
    end else if (accum_i) begin
      acc0_d = acc0_q + AW'(s0_i);
      acc1_d = acc1_q + AW'(s1_i);
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc0_q <= '0;
      acc1_q <= '0;
      cnt_q  <= '0;
    end else begin
      acc0_q <= acc0_d;
      acc1_q <= acc1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last_o    = (cnt_q == CW'((1 << AVG_LOG2) - 1));
  assign avg0_o    = acc0_q[AW-1:AVG_LOG2];
  assign avg1_o    = acc1_q[AW-1:AVG_LOG2];
  assign changed_o = exceeds(avg0_o, pub0_i) || exceeds(avg1_o, pub1_i);

endmodule

// File: rtl/adc_param_scheduler.sv
// Paces ADC conversions, averages duty/period samples and publishes them to
// the clock divider only on master-period boundaries.
module adc_param_scheduler
  import timekeeper_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
  parameter int AVG_LOG2   = 2,
  parameter int HYST       = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  start_o,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] ch0_i,
  input  logic [DATA_WIDTH-1:0] ch1_i,
  input  logic                  boundary_i,
  output logic [DATA_WIDTH-1:0] duty_o,
  output logic [DATA_WIDTH-1:0] period_o,
  output logic                  update_o,
  output logic                  busy_o,
  output logic                  timeout_err_o
);

  localparam int TW = $clog2(SAMPLE_DIV + 1);
  localparam int OW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] RELOAD = TW'(SAMPLE_DIV - 1);

  sched_state_e          state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [OW-1:0]         tout_q, tout_d;
  logic                  tick_q, tick_d;
  logic [DATA_WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] pd_q, pd_d, pp_q, pp_d;
  logic [DATA_WIDTH-1:0] duty_q, duty_d, period_q, period_d;
  logic                  upd_q, upd_d, first_q, first_d, err_q, err_d;

  logic                  do_accum, do_eval, last, changed;
  logic [DATA_WIDTH-1:0] avg0, avg1;

  assign do_accum = (state_q == ST_ACCUM);
  assign do_eval  = (state_q == ST_EVAL);

  sample_averager #(
    .DATA_WIDTH(DATA_WIDTH),
    .AVG_LOG2  (AVG_LOG2),
    .HYST      (HYST)
  ) u_avg (
    .clk      (clk),
    .rst      (rst),
    .accum_i  (do_accum),
    .clear_i  (do_eval),
    .s0_i     (s0_q),
    .s1_i     (s1_q),
    .pub0_i   (duty_q),
    .pub1_i   (period_q),
    .last_o   (last),
    .avg0_o   (avg0),
    .avg1_o   (avg1),
    .changed_o(changed)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = (timer_q == '0) ? RELOAD : timer_q - 1'b1;
    tout_d   = tout_q;
    tick_d   = tick_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    err_d    = err_q;
    pend_d   = pend_q;
    pd_d     = pd_q;
    pp_d     = pp_q;
    duty_d   = duty_q;
    period_d = period_q;
    upd_d    = 1'b0;
    first_d  = first_q;

    unique case (state_q)
      ST_IDLE: begin
        if (tick_q) begin
          state_d = ST_START;
          tick_d  = 1'b0;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
        tout_d  = '0;
      end
      ST_WAIT: begin
        if (valid_i) begin
          s0_d    = ch0_i;
          s1_d    = ch1_i;
          state_d = ST_ACCUM;
        end else if (tout_q == OW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tout_d = tout_q + 1'b1;
        end
      end
      ST_ACCUM: state_d = last ? ST_EVAL : ST_IDLE;
      ST_EVAL:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // A timer expiry while a tick is still pending simply merges into it.
    if (timer_q == '0) tick_d = 1'b1;

    if (pend_q && (first_q || boundary_i)) begin
      duty_d   = pd_q;
      period_d = pp_q;
      upd_d    = 1'b1;
      pend_d   = 1'b0;
      first_d  = 1'b0;
    end
    // A fresh candidate overrides the pending slot; it waits for a later boundary.
    if (do_eval && (first_q || changed)) begin
      pend_d = 1'b1;
      pd_d   = avg0;
      pp_d   = avg1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= RELOAD;
      tout_q   <= '0;
      tick_q   <= 1'b0;
      s0_q     <= '0;
      s1_q     <= '0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      pd_q     <= '0;
      pp_q     <= '0;
      duty_q   <= '0;
      period_q <= '0;
      upd_q    <= 1'b0;
      first_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      tout_q   <= tout_d;
      tick_q   <= tick_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      pd_q     <= pd_d;
      pp_q     <= pp_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      upd_q    <= upd_d;
      first_q  <= first_d;
    end
  end

  assign start_o       = (state_q == ST_START) && !rst;
  assign busy_o        = (state_q == ST_WAIT);
  assign update_o      = upd_q;
  assign duty_o        = duty_q;
  assign period_o      = period_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_adc_param_scheduler.sv
// Bench for adc_param_scheduler: timestamp-based reference model, scripted
// scenarios followed by a randomized soak.
module tb_adc_param_scheduler;

  localparam int DW = 10;
  localparam int SD = 16;
  localparam int AL = 2;
  localparam int HY = 4;
  localparam int TO = 32;
  localparam int NS = 1 << AL;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_o, valid_i, boundary_i;
  logic [DW-1:0] ch0_i, ch1_i, duty_o, period_o;
  logic          update_o, busy_o, timeout_err_o;

  always #5 clk = ~clk;

  adc_param_scheduler #(
    .DATA_WIDTH(DW),
    .SAMPLE_DIV(SD),
    .AVG_LOG2  (AL),
    .HYST      (HY),
    .TIMEOUT   (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_o      (start_o),
    .valid_i      (valid_i),
    .ch0_i        (ch0_i),
    .ch1_i        (ch1_i),
    .boundary_i   (boundary_i),
    .duty_o       (duty_o),
    .period_o     (period_o),
    .update_o     (update_o),
    .busy_o       (busy_o),
    .timeout_err_o(timeout_err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: times in cycles since the last reset edge.
  int k;
  bit m_tick, m_pend, m_first, m_upd, m_err;
  int m_free_at, m_conv_s, m_eval_at;
  int m_sum0, m_sum1, m_nsamp;
  int m_pd, m_pp, m_duty, m_period;

  // Stimulus state.
  int g = 0;
  int valid_at = -1;
  logic [DW-1:0] nv0, nv1;
  int conv_idx = 0;
  int no_resp_idx = -1;
  int resp_delay = 5;
  bit rand_bnd = 0;
  int rb0 = 500, rb1 = 500;
  int samp0_q[$], samp1_q[$], bnd_q[$];

  // Observations of the DUT for the literal checks.
  int starts_k[$];
  int upd_cnt, upd_k, upd_duty, upd_period, err_rise_k;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", name, got, exp, k);
    end
  endtask

  task automatic model_reset();
    k = 0;
    m_tick = 0; m_pend = 0; m_first = 1; m_upd = 0; m_err = 0;
    m_free_at = 0; m_conv_s = -1; m_eval_at = -1;
    m_sum0 = 0; m_sum1 = 0; m_nsamp = 0;
    m_pd = 0; m_pp = 0; m_duty = 0; m_period = 0;
  endtask

  task automatic clear_obs();
    starts_k.delete();
    upd_cnt = 0; upd_k = -1; upd_duty = -1; upd_period = -1; err_rise_k = -1;
  endtask

  task automatic model_step(input bit r, input bit v, input bit b, input int c0, input int c1);
    bit idle_now, n_pend, n_upd, n_first;
    int n_pd, n_pp, n_duty, n_period, a0, a1, d0, d1;
    if (r) begin
      model_reset();
      return;
    end
    idle_now = (m_conv_s < 0) && (k >= m_free_at);
    n_pend = m_pend; n_pd = m_pd; n_pp = m_pp;
    n_duty = m_duty; n_period = m_period; n_first = m_first; n_upd = 0;
    if (m_pend && (m_first || b)) begin
      n_duty = m_pd; n_period = m_pp; n_upd = 1; n_pend = 0; n_first = 0;
    end
    if (k == m_eval_at) begin
      a0 = m_sum0 / NS;
      a1 = m_sum1 / NS;
      d0 = a0 - m_duty;   if (d0 < 0) d0 = -d0;
      d1 = a1 - m_period; if (d1 < 0) d1 = -d1;
      if (m_first || d0 > HY || d1 > HY) begin
        n_pend = 1; n_pd = a0; n_pp = a1;
      end
      m_sum0 = 0; m_sum1 = 0; m_nsamp = 0; m_eval_at = -1;
    end
    if (m_conv_s >= 0 && k > m_conv_s) begin
      if (v) begin
        m_sum0 += c0; m_sum1 += c1; m_nsamp++;
        m_conv_s = -1;
        if (m_nsamp == NS) begin
          m_eval_at = k + 2;
          m_free_at = k + 3;
        end else begin
          m_free_at = k + 2;
        end
      end else if (k == m_conv_s + TO) begin
        m_err = 1;
        m_conv_s = -1;
        m_free_at = k + 1;
      end
    end
    if (idle_now && m_tick) begin
      m_tick = 0;
      m_conv_s = k + 1;
    end
    if (k % SD == SD - 1) m_tick = 1;
    m_pend = n_pend; m_pd = n_pd; m_pp = n_pp;
    m_duty = n_duty; m_period = n_period; m_first = n_first; m_upd = n_upd;
    k++;
  endtask

  task automatic cycle(input bit r);
    bit s_exp, b_exp, v, b;
    int d;
    @(posedge clk);
    #1;
    s_exp = (k == m_conv_s) && !r;
    b_exp = (m_conv_s >= 0) && (k > m_conv_s);
    if (rand_bnd) begin
      b = ($urandom_range(0, 24) == 0);
    end else begin
      b = (bnd_q.size() > 0) && (bnd_q[0] == k);
      if (b) void'(bnd_q.pop_front());
    end
    v = (g == valid_at);
    rst        = r;
    valid_i    = v;
    boundary_i = b;
    ch0_i      = v ? nv0 : DW'($urandom_range(0, 1023));
    ch1_i      = v ? nv1 : DW'($urandom_range(0, 1023));
    if (s_exp) begin
      if (conv_idx != no_resp_idx && !(resp_delay == 0 && $urandom_range(0, 6) == 0)) begin
        d = (resp_delay > 0) ? resp_delay : int'($urandom_range(1, TO));
        valid_at = g + d;
        if (samp0_q.size() > 0) begin
          nv0 = DW'(samp0_q.pop_front());
          nv1 = DW'(samp1_q.pop_front());
        end else begin
          if ($urandom_range(0, 7) == 0) rb0 = int'($urandom_range(20, 1000));
          if ($urandom_range(0, 7) == 0) rb1 = int'($urandom_range(20, 1000));
          nv0 = DW'(rb0 + int'($urandom_range(0, 8)) - 4);
          nv1 = DW'(rb1 + int'($urandom_range(0, 8)) - 4);
        end
      end else begin
        valid_at = -1;
      end
      conv_idx++;
    end
    @(negedge clk);
    check("start_o", 32'(start_o), 32'(s_exp));
    check("busy_o", 32'(busy_o), 32'(b_exp));
    check("update_o", 32'(update_o), 32'(m_upd));
    check("duty_o", 32'(duty_o), m_duty);
    check("period_o", 32'(period_o), m_period);
    check("timeout_err_o", 32'(timeout_err_o), 32'(m_err));
    if (start_o === 1'b1) starts_k.push_back(k);
    if (update_o === 1'b1) begin
      upd_cnt++; upd_k = k; upd_duty = int'(duty_o); upd_period = int'(period_o);
    end
    if (timeout_err_o === 1'b1 && err_rise_k < 0) err_rise_k = k;
    model_step(r, v, b, int'(ch0_i), int'(ch1_i));
    if (r) conv_idx = 0;
    g++;
  endtask

  task automatic run_to(input int target);
    while (k < target) cycle(1'b0);
  endtask

  task automatic queue_samples(input int c0, input int c1, input int n);
    for (int i = 0; i < n; i++) begin
      samp0_q.push_back(c0);
      samp1_q.push_back(c1);
    end
  endtask

  initial begin
    int nxt;
    rst = 1'b1; valid_i = 1'b0; boundary_i = 1'b0; ch0_i = '0; ch1_i = '0;
    model_reset();
    clear_obs();
    repeat (3) cycle(1'b1);
    clear_obs();

    // Scripted timeline: first publish, sub-hysteresis batch, boundary-gated
    // publish, overwritten candidate, then a timed-out conversion.
    queue_samples(100, 400, 4);
    samp0_q.push_back(102); samp1_q.push_back(400);
    samp0_q.push_back(103); samp1_q.push_back(400);
    samp0_q.push_back(101); samp1_q.push_back(400);
    samp0_q.push_back(102); samp1_q.push_back(400);
    queue_samples(110, 400, 4);
    queue_samples(110, 500, 4);
    queue_samples(110, 600, 4);
    queue_samples(130, 600, 4);
    bnd_q.push_back(250);
    bnd_q.push_back(340);
    no_resp_idx = 21;

    run_to(80);
    check("first_start_k", (starts_k.size() > 0) ? starts_k[0] : -1, 17);
    check("first_pub_k", upd_k, 74);
    check("first_pub_duty", upd_duty, 100);
    check("first_pub_period", upd_period, 400);

    run_to(144);
    check("hyst_no_update", upd_cnt, 1);
    check("hyst_duty_held", 32'(duty_o), 100);

    run_to(252);
    check("bnd_pub_count", upd_cnt, 2);
    check("bnd_pub_k", upd_k, 251);
    check("bnd_pub_duty", upd_duty, 110);

    run_to(344);
    check("overwrite_count", upd_cnt, 3);
    check("overwrite_k", upd_k, 341);
    check("overwrite_period", upd_period, 600);

    run_to(436);
    check("timeout_rise_k", err_rise_k, 386);
    nxt = -1;
    foreach (starts_k[i]) if (starts_k[i] == 353 && i + 1 < starts_k.size()) nxt = starts_k[i + 1];
    check("start_after_timeout", nxt, 387);
    check("busy_before_rst", 32'(busy_o), 1);

    // Reset mid-WAIT with a candidate pending.
    cycle(1'b1);
    clear_obs();
    no_resp_idx = -1;
    queue_samples(200, 300, 4);
    run_to(1);
    check("rst_duty", 32'(duty_o), 0);
    check("rst_period", 32'(period_o), 0);
    check("rst_err", 32'(timeout_err_o), 0);
    run_to(80);
    check("post_rst_pub_count", upd_cnt, 1);
    check("post_rst_pub_k", upd_k, 74);
    check("post_rst_pub_duty", upd_duty, 200);
    check("post_rst_pub_period", upd_period, 300);

    // Randomized soak against the model.
    resp_delay = 0;
    rand_bnd   = 1;
    repeat (3000) cycle($urandom_range(0, 999) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
